uart_prog_loader: RTL and testbench

Parametrised program/data loader between the UART byte receiver and the pipelined CPU datapath. It replaces the fixed 16-bit `uart_en`/`uart_sel`/`uart_data` load path with a framed byte protocol. Each frame carries a target memory, a start address, a word count, a payload and an XOR checksum. Bytes are assembled into DATA_W-bit words, written with an auto-incrementing address, and the CPU is held (stall) until a RUN command releases it.

---
 rtl/uart_prog_loader_pkg.sv | 24 ++
 rtl/uart_prog_loader_word_assembler.sv | 42 ++++
 rtl/uart_prog_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program/data loader: FSM states,
// frame header codes and the bytes-per-word helper.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR_L = 3'd1,
    S_ADDR_H = 3'd2,
    S_CNT_L  = 3'd3,
    S_CNT_H  = 3'd4,
    S_DATA   = 3'd5,
    S_CSUM   = 3'd6
  } state_t;

  localparam logic [7:0] HDR_DMEM = 8'h01;
  localparam logic [7:0] HDR_IMEM = 8'h02;
  localparam logic [7:0] HDR_RUN  = 8'h03;

  // Number of payload bytes that make up one memory word.
  function automatic int BYTES_PER_WORD(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_prog_loader_word_assembler.sv
// Little-endian byte-to-word assembler. The first byte of a word lands in
// the least significant byte. word_done/word are combinational so the
// caller can register the write strobe in the same cycle as the last byte.
module word_assembler
  import loader_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [7:0]        data_byte,
  output logic              word_done,
  output logic [DATA_W-1:0] word
);

  localparam int BPW   = BYTES_PER_WORD(DATA_W);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] shift_r;

  // New byte enters at the top, earlier bytes move down one byte lane.
  assign word      = (shift_r >> 8) | (DATA_W'(data_byte) << (DATA_W - 8));
  assign word_done = valid && (idx_r == IDX_W'(BPW - 1));

  // Shift register and byte index; clear discards any partial word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_r   <= {IDX_W{1'b0}};
      shift_r <= {DATA_W{1'b0}};
    end else if (valid) begin
      shift_r <= word;
      idx_r   <= word_done ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
    end else begin
      idx_r   <= idx_r;
      shift_r <= shift_r;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Framed UART loader: parses HDR/ADDR/CNT/payload/CSUM frames, writes
// assembled words to instruction or data memory and holds the CPU until RUN.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state_r, state_next;
  logic              is_imem_r, is_imem_next;
  logic [7:0]        addr_lo_r, addr_lo_next;
  logic [ADDR_W-1:0] addr_r, addr_next;
  logic [7:0]        cnt_lo_r, cnt_lo_next;
  logic [15:0]       cnt_r, cnt_next;
  logic [7:0]        csum_r, csum_next;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_next;
  logic              hold_r, hold_next;
  logic              imem_we_r, imem_we_next;
  logic              dmem_we_r, dmem_we_next;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_next;
  logic              done_r, done_next;
  logic              err_r, err_next;
  logic              busy_r;

  logic              asm_valid_s;
  logic              asm_clear_s;
  logic              word_done_s;
  logic [DATA_W-1:0] word_s;

  // Payload bytes only feed the assembler in DATA; any other state flushes it.
  assign asm_valid_s = rx_valid && (state_r == S_DATA);
  assign asm_clear_s = (state_r != S_DATA);

  word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear_s),
    .valid     (asm_valid_s),
    .data_byte (rx_byte),
    .word_done (word_done_s),
    .word      (word_s)
  );

  // Frame parser: next state, counters, checksum and next output values.
  always_comb begin
    state_next     = state_r;
    is_imem_next   = is_imem_r;
    addr_lo_next   = addr_lo_r;
    addr_next      = addr_r;
    cnt_lo_next    = cnt_lo_r;
    cnt_next       = cnt_r;
    csum_next      = csum_r;
    hold_next      = hold_r;
    mem_addr_next  = mem_addr_r;
    mem_wdata_next = mem_wdata_r;
    imem_we_next   = 1'b0;
    dmem_we_next   = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;
    to_cnt_next    = {TO_W{1'b0}};

    case (state_r)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            HDR_DMEM, HDR_IMEM: begin
              hold_next    = 1'b1;
              is_imem_next = (rx_byte == HDR_IMEM);
              csum_next    = 8'h00;
              state_next   = S_ADDR_L;
            end
            HDR_RUN: begin
              hold_next = 1'b0;
              done_next = 1'b1;
            end
            default: begin
              err_next = 1'b1;
            end
          endcase
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ADDR_L: begin
        if (rx_valid) begin
          addr_lo_next = rx_byte;
          csum_next    = csum_r ^ rx_byte;
          state_next   = S_ADDR_H;
        end else begin
          state_next = S_ADDR_L;
        end
      end
      S_ADDR_H: begin
        if (rx_valid) begin
          // Upper address bits beyond ADDR_W are dropped but still checksummed.
          addr_next  = ADDR_W'({rx_byte, addr_lo_r});
          csum_next  = csum_r ^ rx_byte;
          state_next = S_CNT_L;
        end else begin
          state_next = S_ADDR_H;
        end
      end
      S_CNT_L: begin
        if (rx_valid) begin
          cnt_lo_next = rx_byte;
          csum_next   = csum_r ^ rx_byte;
          state_next  = S_CNT_H;
        end else begin
          state_next = S_CNT_L;
        end
      end
      S_CNT_H: begin
        if (rx_valid) begin
          cnt_next   = {rx_byte, cnt_lo_r};
          csum_next  = csum_r ^ rx_byte;
          state_next = ({rx_byte, cnt_lo_r} == 16'h0000) ? S_CSUM : S_DATA;
        end else begin
          state_next = S_CNT_H;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          csum_next = csum_r ^ rx_byte;
          if (word_done_s) begin
            imem_we_next   = is_imem_r;
            dmem_we_next   = !is_imem_r;
            mem_addr_next  = addr_r;
            mem_wdata_next = word_s;
            addr_next      = addr_r + ADDR_W'(1'b1);
            cnt_next       = cnt_r - 16'd1;
            state_next     = (cnt_r == 16'd1) ? S_CSUM : S_DATA;
          end else begin
            state_next = S_DATA;
          end
        end else begin
          state_next = S_DATA;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_r) begin
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = S_IDLE;
        end else begin
          state_next = S_CSUM;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Inter-byte timeout; an arriving byte always beats an expiring counter.
    if (state_r != S_IDLE) begin
      if (rx_valid) begin
        to_cnt_next = {TO_W{1'b0}};
      end else if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
        err_next    = 1'b1;
        state_next  = S_IDLE;
        to_cnt_next = {TO_W{1'b0}};
      end else begin
        to_cnt_next = to_cnt_r + TO_W'(1'b1);
      end
    end else begin
      to_cnt_next = {TO_W{1'b0}};
    end
  end

  // State and output registers; reset discards any frame and re-holds the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      is_imem_r   <= 1'b0;
      addr_lo_r   <= 8'h00;
      addr_r      <= {ADDR_W{1'b0}};
      cnt_lo_r    <= 8'h00;
      cnt_r       <= 16'h0000;
      csum_r      <= 8'h00;
      to_cnt_r    <= {TO_W{1'b0}};
      hold_r      <= 1'b1;
      imem_we_r   <= 1'b0;
      dmem_we_r   <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next;
      is_imem_r   <= is_imem_next;
      addr_lo_r   <= addr_lo_next;
      addr_r      <= addr_next;
      cnt_lo_r    <= cnt_lo_next;
      cnt_r       <= cnt_next;
      csum_r      <= csum_next;
      to_cnt_r    <= to_cnt_next;
      hold_r      <= hold_next;
      imem_we_r   <= imem_we_next;
      dmem_we_r   <= dmem_we_next;
      mem_addr_r  <= mem_addr_next;
      mem_wdata_r <= mem_wdata_next;
      done_r      <= done_next;
      err_r       <= err_next;
      busy_r      <= (state_next != S_IDLE);
    end
  end

  assign imem_we   = imem_we_r;
  assign dmem_we   = dmem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_hold  = hold_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed frames from the test
// plan plus random frames, checked against a frame-level reference model.
module tb_uart_prog_loader;

  localparam int DW_A = 16;
  localparam int AW_A = 16;
  localparam int DW_B = 32;
  localparam int AW_B = 12;
  localparam int TO   = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            rxv_a, rxv_b;
  logic [7:0]      rxb_a, rxb_b;
  logic            imem_we_a, dmem_we_a, hold_a, busy_a, done_a, err_a;
  logic [AW_A-1:0] addr_a;
  logic [DW_A-1:0] wdata_a;
  logic            imem_we_b, dmem_we_b, hold_b, busy_b, done_b, err_b;
  logic [AW_B-1:0] addr_b;
  logic [DW_B-1:0] wdata_b;

  uart_prog_loader #(.DATA_W(DW_A), .ADDR_W(AW_A), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .reset(reset), .rx_valid(rxv_a), .rx_byte(rxb_a),
    .imem_we(imem_we_a), .dmem_we(dmem_we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .cpu_hold(hold_a), .busy(busy_a),
    .done(done_a), .err(err_a)
  );

  uart_prog_loader #(.DATA_W(DW_B), .ADDR_W(AW_B), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rxv_b), .rx_byte(rxb_b),
    .imem_we(imem_we_b), .dmem_we(dmem_we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .cpu_hold(hold_b), .busy(busy_b),
    .done(done_b), .err(err_b)
  );

  typedef struct {
    logic        imem;
    logic [15:0] addr;
    logic [63:0] data;
    int          c;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  obs_wr[$];
  wr_t  exp_wr[$];
  int   obs_done = 0, obs_err = 0, done_cyc = 0, err_cyc = 0;
  int   exp_done_n, exp_err_n;
  logic exp_hold_a, exp_hold_b;
  logic [7:0] fr[$];
  int   byte_cyc[$];
  int   last_cyc;

  // Cycle counter used to time-stamp bytes and observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: collects writes/done/err and checks pulse exclusivity.
  always @(negedge clk) begin
    checks++;
    assert (!(done_a && err_a) && !(imem_we_a && dmem_we_a) &&
            !(done_b && err_b) && !(imem_we_b && dmem_we_b))
    else begin
      errors++;
      $error("FAIL exclusive_pulses: observed a=%b%b%b%b b=%b%b%b%b expected no overlap",
             done_a, err_a, imem_we_a, dmem_we_a, done_b, err_b, imem_we_b, dmem_we_b);
    end
    if (imem_we_a || dmem_we_a)
      obs_wr.push_back('{imem: imem_we_a, addr: 16'(addr_a), data: 64'(wdata_a), c: cyc});
    if (imem_we_b || dmem_we_b)
      obs_wr.push_back('{imem: imem_we_b, addr: 16'(addr_b), data: 64'(wdata_b), c: cyc});
    if (done_a || done_b) begin
      obs_done++;
      done_cyc = cyc;
    end
    if (err_a || err_b) begin
      obs_err++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte, one cycle of rx_valid; time-stamp taken after the sampling edge.
  task automatic send(input bit sel, input logic [7:0] b);
    if (!sel) begin rxv_a = 1'b1; rxb_a = b; end
    else begin rxv_b = 1'b1; rxb_b = b; end
    @(negedge clk);
    last_cyc = cyc;
    byte_cyc.push_back(cyc);
    rxv_a = 1'b0;
    rxv_b = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input int maxgap);
    byte_cyc.delete();
    foreach (fr[i]) begin
      send(sel, fr[i]);
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    end
  endtask

  // Build a load frame with random payload; bad checksum when good == 0.
  task automatic build_load(input logic [7:0] hdr, input logic [15:0] a,
                            input int n, input int dw, input bit good);
    logic [7:0] x;
    fr.delete();
    fr.push_back(hdr);
    fr.push_back(a[7:0]);
    fr.push_back(a[15:8]);
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    for (int i = 0; i < n * (dw / 8); i++) fr.push_back(8'($urandom));
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x ^= fr[i];
    fr.push_back(good ? x : (x ^ 8'(1 + $urandom_range(254, 0))));
  endtask

  // Frame-level reference: expected writes, outcome and hold from frame bytes.
  task automatic model_frame(input bit sel, input int dw, input int aw);
    int a, n, bpw;
    logic [7:0]  x;
    logic [63:0] w;
    exp_wr.delete();
    exp_done_n = 0;
    exp_err_n  = 0;
    if (fr[0] == 8'h03) begin
      exp_done_n = 1;
      if (sel) exp_hold_b = 1'b0; else exp_hold_a = 1'b0;
    end else if (fr[0] == 8'h01 || fr[0] == 8'h02) begin
      if (sel) exp_hold_b = 1'b1; else exp_hold_a = 1'b1;
      bpw = dw / 8;
      a = int'({fr[2], fr[1]}) % (1 << aw);
      n = int'({fr[4], fr[3]});
      for (int k = 0; k < n; k++) begin
        w = 64'h0;
        for (int j = 0; j < bpw; j++) w |= 64'(fr[5 + k * bpw + j]) << (8 * j);
        exp_wr.push_back('{imem: (fr[0] == 8'h02), addr: 16'(a), data: w,
                           c: byte_cyc[4 + (k + 1) * bpw]});
        a = (a + 1) % (1 << aw);
      end
      x = 8'h00;
      for (int i = 1; i < fr.size() - 1; i++) x ^= fr[i];
      if (x == fr[fr.size() - 1]) exp_done_n = 1; else exp_err_n = 1;
    end else begin
      exp_err_n = 1;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag, input bit sel);
    int m;
    chk({tag, " nwr"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    m = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), 64'(obs_wr[i].addr), 64'(exp_wr[i].addr));
      chk($sformatf("%s wr%0d data", tag, i), obs_wr[i].data, exp_wr[i].data);
      chk($sformatf("%s wr%0d imem", tag, i), 64'(obs_wr[i].imem), 64'(exp_wr[i].imem));
      chk($sformatf("%s wr%0d cyc", tag, i), 64'(obs_wr[i].c), 64'(exp_wr[i].c));
    end
    chk({tag, " done"}, 64'(obs_done), 64'(exp_done_n));
    chk({tag, " err"}, 64'(obs_err), 64'(exp_err_n));
    if (exp_done_n == 1 && obs_done == 1)
      chk({tag, " done_lat"}, 64'(done_cyc), 64'(last_cyc));
    chk({tag, " hold"}, 64'(sel ? hold_b : hold_a), 64'(sel ? exp_hold_b : exp_hold_a));
    chk({tag, " busy"}, 64'(sel ? busy_b : busy_a), 64'h0);
    obs_wr.delete();
    obs_done = 0;
    obs_err  = 0;
  endtask

  initial begin
    int r;
    reset = 1'b1;
    rxv_a = 1'b0; rxb_a = 8'h00;
    rxv_b = 1'b0; rxb_b = 8'h00;
    exp_hold_a = 1'b1;
    exp_hold_b = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst hold", 64'(hold_a), 64'h1);
    chk("rst busy", 64'(busy_a), 64'h0);
    chk("rst addr", 64'(addr_a), 64'h0);
    chk("rst wdata", 64'(wdata_a), 64'h0);
    chk("rst strobes", 64'({imem_we_a, dmem_we_a, done_a, err_a}), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Good imem frame, back-to-back bytes
    fr = '{8'h02, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h1A};
    send_frame(1'b0, 0);
    settle();
    chk("imem0 addr", (obs_wr.size() > 0) ? 64'(obs_wr[0].addr) : 64'hdead, 64'h0010);
    chk("imem0 data", (obs_wr.size() > 0) ? obs_wr[0].data : 64'hdead, 64'h1234);
    chk("imem1 addr", (obs_wr.size() > 1) ? 64'(obs_wr[1].addr) : 64'hdead, 64'h0011);
    chk("imem1 data", (obs_wr.size() > 1) ? obs_wr[1].data : 64'hdead, 64'h5678);
    model_frame(1'b0, DW_A, AW_A);
    compare("imem_good", 1'b0);

    // Same frame, bad checksum
    fr[9] = 8'h1B;
    send_frame(1'b0, 0);
    settle();
    model_frame(1'b0, DW_A, AW_A);
    compare("imem_badcsum", 1'b0);

    // RUN releases the CPU
    fr = '{8'h03};
    send_frame(1'b0, 0);
    settle();
    chk("run hold", 64'(hold_a), 64'h0);
    model_frame(1'b0, DW_A, AW_A);
    compare("run", 1'b0);

    // Unknown header: err only, hold unchanged
    fr = '{8'h07};
    send_frame(1'b0, 0);
    settle();
    model_frame(1'b0, DW_A, AW_A);
    compare("bad_hdr", 1'b0);

    // Address wrap at top of memory
    fr = '{8'h01, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'h02};
    send_frame(1'b0, 1);
    settle();
    chk("wrap0 addr", (obs_wr.size() > 0) ? 64'(obs_wr[0].addr) : 64'hdead, 64'hFFFF);
    chk("wrap1 addr", (obs_wr.size() > 1) ? 64'(obs_wr[1].addr) : 64'hdead, 64'h0000);
    model_frame(1'b0, DW_A, AW_A);
    compare("wrap", 1'b0);

    // Timeout after 3 data bytes: one write, err exactly TO cycles later
    fr = '{8'h01, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_frame(1'b0, 0);
    repeat (TO + 10) @(negedge clk);
    chk("timeout lat", 64'(err_cyc - last_cyc), 64'(TO));
    exp_wr.delete();
    exp_wr.push_back('{imem: 1'b0, addr: 16'h0010, data: 64'h2211, c: byte_cyc[6]});
    exp_done_n = 0;
    exp_err_n  = 1;
    exp_hold_a = 1'b1;
    compare("timeout", 1'b0);

    // Reset arriving with the byte that would complete a word
    fr = '{8'h03};
    send_frame(1'b0, 0);
    settle();
    model_frame(1'b0, DW_A, AW_A);
    compare("run2", 1'b0);
    fr = '{8'h01, 8'h20, 8'h00, 8'h01, 8'h00, 8'hAB};
    send_frame(1'b0, 0);
    rxv_a = 1'b1; rxb_a = 8'hCD; reset = 1'b1;
    @(negedge clk);
    rxv_a = 1'b0; reset = 1'b0;
    settle();
    exp_wr.delete();
    exp_done_n = 0;
    exp_err_n  = 0;
    exp_hold_a = 1'b1;
    compare("reset_mid", 1'b0);

    // Random traffic on the 16-bit loader
    for (int f = 0; f < 20; f++) begin
      r = $urandom_range(99, 0);
      if (r < 70) begin
        build_load(($urandom_range(1, 0) != 0) ? 8'h02 : 8'h01, 16'($urandom),
                   $urandom_range(4, 0), DW_A, ($urandom_range(3, 0) != 0));
      end else if (r < 85) begin
        fr = '{8'h03};
      end else begin
        fr.delete();
        fr.push_back(8'($urandom_range(255, 4)));
      end
      send_frame(1'b0, 3);
      settle();
      model_frame(1'b0, DW_A, AW_A);
      compare($sformatf("rand%0d", f), 1'b0);
    end

    // 32-bit loader: empty frame, then a random two-word frame
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b1, 0);
    settle();
    model_frame(1'b1, DW_B, AW_B);
    compare("w32_cnt0", 1'b1);
    build_load(8'h02, 16'($urandom), 2, DW_B, 1'b1);
    send_frame(1'b1, 2);
    settle();
    model_frame(1'b1, DW_B, AW_B);
    compare("w32_rand", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
